// File: rtl/tx_inband_pkg.sv
// Shared definitions for the in-band TX packet path.
//   CHAN_LSB/CHAN_MSB : location of the channel field inside a header word
//   CMD_CHAN          : channel field value that selects the command channel
//   state_e           : router packet state
package tx_inband_pkg;

  localparam int unsigned CHAN_LSB = 16;
  localparam int unsigned CHAN_MSB = 20;
  localparam logic [4:0]  CMD_CHAN = 5'h1F;

  typedef enum logic [1:0] {
    StIdle,
    StRoute,
    StDrop
  } state_e;

endpackage

// File: rtl/tx_hdr_decode.sv
// Header decoder: maps the channel field of a header word to a one-hot target
// and decides whether the packet can be accepted.
// Ports:
//   i_chan            channel field taken from the header word
//   i_chan_enable     per-data-channel enable
//   i_chan_have_space per-channel room-for-one-packet flags (command at NUM_CHAN)
//   o_sel             one-hot target (command channel at bit NUM_CHAN)
//   o_accept          1 when the target exists, is enabled and has room
module tx_hdr_decode
  import tx_inband_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 2
) (
  input  logic [4:0]          i_chan,
  input  logic [NUM_CHAN-1:0] i_chan_enable,
  input  logic [NUM_CHAN:0]   i_chan_have_space,
  output logic [NUM_CHAN:0]   o_sel,
  output logic                o_accept
);

  always_comb begin
    o_sel    = '0;
    o_accept = 1'b0;
    if (i_chan == CMD_CHAN) begin
      // The command channel has no enable; only room matters.
      o_sel[NUM_CHAN] = 1'b1;
      o_accept        = i_chan_have_space[NUM_CHAN];
    end else begin
      // Channel numbers at or beyond NUM_CHAN match nothing and are rejected.
      for (int i = 0; i < int'(NUM_CHAN); i++) begin
        if (i_chan == 5'(i)) begin
          o_sel[i] = 1'b1;
          o_accept = i_chan_enable[i] & i_chan_have_space[i];
        end
      end
    end
  end

endmodule

// File: rtl/tx_chan_router.sv
// TX channel router: takes a packed 32-bit word stream of fixed-length packets,
// decodes the header of each packet and steers all of its words to one channel
// RAM, or discards the packet and counts the drop.
// Ports:
//   txclk            clock, all logic on posedge
//   reset            synchronous active-low reset
//   data_in          packed word stream
//   data_valid       data_in valid this cycle (gaps allowed anywhere)
//   chan_enable      per-data-channel enable
//   chan_have_space  per-channel room for one full packet (command at NUM_CHAN)
//   clear_drops      pulse clearing drop_count
//   ram_data         registered word toward the channel RAMs
//   chan_WR          one-hot write strobe aligned with ram_data
//   chan_done        one-hot end-of-packet pulse, one cycle after the last write
//   have_space       AND of all chan_have_space bits
//   drop_count       saturating count of dropped packets
//   busy             packet in progress
module tx_chan_router
  import tx_inband_pkg::*;
#(
  parameter int unsigned NUM_CHAN  = 2,
  parameter int unsigned PKT_WORDS = 128,
  parameter int unsigned DROP_W    = 16
) (
  input  logic                txclk,
  input  logic                reset,
  input  logic [31:0]         data_in,
  input  logic                data_valid,
  input  logic [NUM_CHAN-1:0] chan_enable,
  input  logic [NUM_CHAN:0]   chan_have_space,
  input  logic                clear_drops,
  output logic [31:0]         ram_data,
  output logic [NUM_CHAN:0]   chan_WR,
  output logic [NUM_CHAN:0]   chan_done,
  output logic                have_space,
  output logic [DROP_W-1:0]   drop_count,
  output logic                busy
);

  localparam int unsigned      CntW    = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(PKT_WORDS - 1);
  localparam logic [DROP_W-1:0] DropMax = '1;

  state_e              r_state;
  state_e              w_state_next;
  logic [CntW-1:0]     r_cnt;
  logic [NUM_CHAN:0]   r_sel;
  logic [NUM_CHAN:0]   r_done_sel;
  logic [NUM_CHAN:0]   r_chan_wr;
  logic [NUM_CHAN:0]   r_chan_done;
  logic [31:0]         r_ram_data;
  logic [DROP_W-1:0]   r_drop;

  logic [NUM_CHAN:0]   w_hdr_sel;
  logic                w_accept;
  logic                w_hdr;
  logic                w_last;
  logic                w_drop_evt;
  logic [NUM_CHAN:0]   w_wr_next;
  logic [NUM_CHAN:0]   w_done_sel_next;

  tx_hdr_decode #(
    .NUM_CHAN (NUM_CHAN)
  ) u_hdr_decode (
    .i_chan            (data_in[CHAN_MSB:CHAN_LSB]),
    .i_chan_enable     (chan_enable),
    .i_chan_have_space (chan_have_space),
    .o_sel             (w_hdr_sel),
    .o_accept          (w_accept)
  );

  // A valid word seen in IDLE is by definition a header.
  assign w_hdr      = data_valid & (r_state == StIdle);
  assign w_drop_evt = w_hdr & ~w_accept;
  // The counter only advances on valid words, so it is 0 at every header.
  assign w_last     = data_valid & (r_state != StIdle) & (r_cnt == LastCnt);

  assign have_space = &chan_have_space;

  // State register.
  always_ff @(posedge txclk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (data_valid) begin
          w_state_next = w_accept ? StRoute : StDrop;
        end
      end
      StRoute, StDrop: begin
        if (w_last) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output decode: next write strobe and end-of-packet target.
  always_comb begin
    w_wr_next       = '0;
    w_done_sel_next = '0;
    busy            = (r_state != StIdle);
    unique case (r_state)
      StIdle: begin
        if (data_valid && w_accept) begin
          w_wr_next = w_hdr_sel;
        end
      end
      StRoute: begin
        if (data_valid) begin
          w_wr_next = r_sel;
        end
        if (w_last) begin
          w_done_sel_next = r_sel;
        end
      end
      StDrop: begin
        w_wr_next = '0;
      end
      default: begin
        w_wr_next = '0;
      end
    endcase
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge txclk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_sel       <= '0;
      r_done_sel  <= '0;
      r_chan_wr   <= '0;
      r_chan_done <= '0;
      r_ram_data  <= '0;
      r_drop      <= '0;
    end else begin
      r_chan_wr <= w_wr_next;
      if (|w_wr_next) begin
        r_ram_data <= data_in;
      end
      // Done is staged through r_done_sel so it lands one cycle after the last
      // write, independent of a back-to-back header reloading r_sel.
      r_done_sel  <= w_done_sel_next;
      r_chan_done <= r_done_sel;
      if (w_hdr) begin
        r_sel <= w_hdr_sel;
      end
      if (data_valid) begin
        r_cnt <= w_last ? '0 : r_cnt + CntW'(1);
      end
      // Clear takes priority but a coinciding drop still counts once.
      if (clear_drops) begin
        r_drop <= w_drop_evt ? DROP_W'(1) : '0;
      end else if (w_drop_evt && (r_drop != DropMax)) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  assign ram_data   = r_ram_data;
  assign chan_WR    = r_chan_wr;
  assign chan_done  = r_chan_done;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_tx_chan_router.sv
module tb_tx_chan_router;

  localparam int N  = 2;
  localparam int PW = 4;

  logic        txclk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic [1:0]  chan_enable = 2'b11;
  logic [2:0]  chan_have_space = 3'b111;
  logic        clear_drops = 1'b0;

  logic [31:0] ram_a, ram_b;
  logic [2:0]  wr_a, wr_b, done_a, done_b;
  logic        hs_a, hs_b, busy_a, busy_b;
  logic [15:0] drop_a;
  logic [1:0]  drop_b;

  always #5 txclk = ~txclk;

  tx_chan_router #(.NUM_CHAN(N), .PKT_WORDS(PW), .DROP_W(16)) u_dut (
    .txclk(txclk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .chan_enable(chan_enable), .chan_have_space(chan_have_space),
    .clear_drops(clear_drops), .ram_data(ram_a), .chan_WR(wr_a),
    .chan_done(done_a), .have_space(hs_a), .drop_count(drop_a), .busy(busy_a)
  );

  // Narrow drop counter instance, fed the same stimulus.
  tx_chan_router #(.NUM_CHAN(N), .PKT_WORDS(PW), .DROP_W(2)) u_dut_w2 (
    .txclk(txclk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .chan_enable(chan_enable), .chan_have_space(chan_have_space),
    .clear_drops(clear_drops), .ram_data(ram_b), .chan_WR(wr_b),
    .chan_done(done_b), .have_space(hs_b), .drop_count(drop_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int wr_cnt[3];
  int done_cnt[3];

  // Reference model: packet-level bookkeeping.
  int          m_seen = 0;   // valid words of the current packet seen so far
  int          m_tgt  = -1;  // routed channel index, -1 when dropping
  int          m_pend = -1;  // channel owed a done pulse next cycle
  int          e_d16  = 0;
  int          e_d2   = 0;
  logic [2:0]  e_wr   = '0;
  logic [2:0]  e_done = '0;
  logic [31:0] e_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, req);
    end
  endtask

  task automatic model_edge();
    int  ch;
    bit  ok;
    int  idx;
    if (!reset) begin
      m_seen = 0; m_tgt = -1; m_pend = -1;
      e_d16 = 0; e_d2 = 0; e_wr = '0; e_done = '0; e_data = '0;
    end else begin
      e_done = (m_pend >= 0) ? 3'(1 << m_pend) : 3'b000;
      m_pend = -1;
      e_wr   = '0;
      if (clear_drops) begin
        e_d16 = 0; e_d2 = 0;
      end
      if (data_valid) begin
        if (m_seen == 0) begin
          ch = int'(data_in[20:16]);
          if (ch == 31) begin
            idx = N; ok = chan_have_space[N];
          end else if (ch < N) begin
            idx = ch; ok = chan_enable[ch] && chan_have_space[ch];
          end else begin
            idx = -1; ok = 1'b0;
          end
          m_tgt = ok ? idx : -1;
          if (!ok) begin
            if (e_d16 < 65535) e_d16++;
            if (e_d2 < 3) e_d2++;
          end
        end
        if (m_tgt >= 0) begin
          e_wr   = 3'(1 << m_tgt);
          e_data = data_in;
        end
        m_seen++;
        if (m_seen == PW) begin
          m_seen = 0;
          if (m_tgt >= 0) m_pend = m_tgt;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge txclk);
    #1;
    cyc++;
    chk("wr",        {29'b0, wr_a},   {29'b0, e_wr});
    chk("ram_data",  ram_a,           e_data);
    chk("done",      {29'b0, done_a}, {29'b0, e_done});
    chk("drop16",    {16'b0, drop_a}, 32'(e_d16));
    chk("drop2",     {30'b0, drop_b}, 32'(e_d2));
    chk("busy",      {31'b0, busy_a}, {31'b0, (m_seen != 0)});
    chk("have_space", {31'b0, hs_a},  {31'b0, &chan_have_space});
    for (int i = 0; i < 3; i++) begin
      if (wr_a[i])   wr_cnt[i]++;
      if (done_a[i]) done_cnt[i]++;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    data_valid = v;
    data_in    = d;
    step();
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 3; i++) begin
      wr_cnt[i]   = 0;
      done_cnt[i] = 0;
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [31:0] d;
    logic [1:0]  en;
    logic [2:0]  sp;
    logic [2:0]  ewr;
    logic [31:0] edata;
    logic [2:0]  edone;
    logic [15:0] edrop;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [31:0] d, logic [1:0] en, logic [2:0] sp,
                              logic [2:0] ewr, logic [31:0] ed, logic [2:0] edn,
                              logic [15:0] edr);
    vec_t t;
    t.rst_n = r; t.v = v; t.d = d; t.en = en; t.sp = sp;
    t.ewr = ewr; t.edata = ed; t.edone = edn; t.edrop = edr;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int          pick;

    // Reset, single ch1 packet, three kinds of drop, back-to-back ch0/ch1.
    tbl.push_back(mk(0, 0, 32'h0,         2'b11, 3'b111, 3'b000, 32'h0,         3'b000, 0));
    tbl.push_back(mk(0, 1, 32'h0001_0000, 2'b11, 3'b111, 3'b000, 32'h0,         3'b000, 0));
    tbl.push_back(mk(1, 1, 32'h0001_A000, 2'b11, 3'b111, 3'b010, 32'h0001_A000, 3'b000, 0));
    tbl.push_back(mk(1, 1, 32'h1111_1111, 2'b11, 3'b111, 3'b010, 32'h1111_1111, 3'b000, 0));
    tbl.push_back(mk(1, 1, 32'h2222_2222, 2'b11, 3'b111, 3'b010, 32'h2222_2222, 3'b000, 0));
    tbl.push_back(mk(1, 1, 32'h3333_3333, 2'b11, 3'b111, 3'b010, 32'h3333_3333, 3'b000, 0));
    tbl.push_back(mk(1, 0, 32'h0,         2'b11, 3'b111, 3'b000, 32'h3333_3333, 3'b010, 0));
    tbl.push_back(mk(1, 0, 32'h0,         2'b11, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 0));
    tbl.push_back(mk(1, 1, 32'h0003_0000, 2'b11, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 1));
    tbl.push_back(mk(1, 1, 32'hD0D0_0001, 2'b11, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 1));
    tbl.push_back(mk(1, 1, 32'hD0D0_0002, 2'b11, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 1));
    tbl.push_back(mk(1, 1, 32'hD0D0_0003, 2'b11, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 1));
    tbl.push_back(mk(1, 1, 32'h0000_1234, 2'b10, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 2));
    tbl.push_back(mk(1, 1, 32'hD0D0_0011, 2'b10, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 2));
    tbl.push_back(mk(1, 1, 32'hD0D0_0012, 2'b10, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 2));
    tbl.push_back(mk(1, 1, 32'hD0D0_0013, 2'b10, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 2));
    tbl.push_back(mk(1, 1, 32'h0001_5678, 2'b11, 3'b101, 3'b000, 32'h3333_3333, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'hD0D0_0021, 2'b11, 3'b101, 3'b000, 32'h3333_3333, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'hD0D0_0022, 2'b11, 3'b101, 3'b000, 32'h3333_3333, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'hD0D0_0023, 2'b11, 3'b101, 3'b000, 32'h3333_3333, 3'b000, 3));
    tbl.push_back(mk(1, 0, 32'h0,         2'b11, 3'b111, 3'b000, 32'h3333_3333, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'h0000_0055, 2'b11, 3'b111, 3'b001, 32'h0000_0055, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'hA1A1_A1A1, 2'b11, 3'b111, 3'b001, 32'hA1A1_A1A1, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'hA2A2_A2A2, 2'b11, 3'b111, 3'b001, 32'hA2A2_A2A2, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'hA3A3_A3A3, 2'b11, 3'b111, 3'b001, 32'hA3A3_A3A3, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'h0001_0066, 2'b11, 3'b111, 3'b010, 32'h0001_0066, 3'b001, 3));
    tbl.push_back(mk(1, 1, 32'hB1B1_B1B1, 2'b11, 3'b111, 3'b010, 32'hB1B1_B1B1, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'hB2B2_B2B2, 2'b11, 3'b111, 3'b010, 32'hB2B2_B2B2, 3'b000, 3));
    tbl.push_back(mk(1, 1, 32'hB3B3_B3B3, 2'b11, 3'b111, 3'b010, 32'hB3B3_B3B3, 3'b000, 3));
    tbl.push_back(mk(1, 0, 32'h0,         2'b11, 3'b111, 3'b000, 32'hB3B3_B3B3, 3'b010, 3));
    tbl.push_back(mk(1, 0, 32'h0,         2'b11, 3'b111, 3'b000, 32'hB3B3_B3B3, 3'b000, 3));

    foreach (tbl[i]) begin
      reset           = tbl[i].rst_n;
      data_valid      = tbl[i].v;
      data_in         = tbl[i].d;
      chan_enable     = tbl[i].en;
      chan_have_space = tbl[i].sp;
      step();
      chk($sformatf("tbl%0d_wr", i),   {29'b0, wr_a},   {29'b0, tbl[i].ewr});
      chk($sformatf("tbl%0d_data", i), ram_a,           tbl[i].edata);
      chk($sformatf("tbl%0d_done", i), {29'b0, done_a}, {29'b0, tbl[i].edone});
      chk($sformatf("tbl%0d_drop", i), {16'b0, drop_a}, {16'b0, tbl[i].edrop});
    end

    // Command channel with data_valid toggling.
    clr_counts();
    chan_enable = 2'b11; chan_have_space = 3'b111;
    drive(1, 32'h001F_0000); drive(0, 32'h0);
    drive(1, 32'hC1C1_0001); drive(0, 32'h0);
    drive(1, 32'hC2C2_0002); drive(0, 32'h0);
    drive(1, 32'hC3C3_0003); drive(0, 32'h0);
    drive(0, 32'h0); drive(0, 32'h0);
    chk("cmd_wr_count",    32'(wr_cnt[2]),   32'd4);
    chk("cmd_done_count",  32'(done_cnt[2]), 32'd1);
    chk("cmd_other_wr",    32'(wr_cnt[0] + wr_cnt[1]), 32'd0);

    // Reset in the middle of a ch0 packet, then a normal ch1 packet.
    clr_counts();
    drive(1, 32'h0000_0000); drive(1, 32'hE0E0_0001);
    reset = 1'b0; drive(0, 32'h0); reset = 1'b1;
    drive(1, 32'h0001_0777); drive(1, 32'hE1E1_0001);
    drive(0, 32'h0);         drive(1, 32'hE1E1_0002);
    drive(1, 32'hE1E1_0003);
    drive(0, 32'h0); drive(0, 32'h0); drive(0, 32'h0);
    chk("rst_ch0_done",  32'(done_cnt[0]), 32'd0);
    chk("rst_ch0_wr",    32'(wr_cnt[0]),   32'd2);
    chk("rst_ch1_wr",    32'(wr_cnt[1]),   32'd4);
    chk("rst_ch1_done",  32'(done_cnt[1]), 32'd1);
    chk("rst_drop",      {16'b0, drop_a},  32'd0);

    // Drop counter saturation and clear.
    clr_counts();
    for (int p = 0; p < 5; p++) begin
      drive(1, 32'h0003_0000);
      for (int w = 1; w < PW; w++) drive(1, 32'hF000_0000 | 32'(w));
    end
    drive(0, 32'h0);
    chk("sat_drop_w2",  {30'b0, drop_b}, 32'd3);
    chk("sat_drop_w16", {16'b0, drop_a}, 32'd5);
    chk("sat_no_wr",    32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2]), 32'd0);
    clear_drops = 1'b1; drive(1, 32'h0003_0000); clear_drops = 1'b0;
    chk("clr_drop_w2",  {30'b0, drop_b}, 32'd1);
    chk("clr_drop_w16", {16'b0, drop_a}, 32'd1);
    for (int w = 1; w < PW; w++) drive(1, 32'hF100_0000 | 32'(w));
    clear_drops = 1'b1; drive(0, 32'h0); clear_drops = 1'b0;
    chk("clr_only_w2",  {30'b0, drop_b}, 32'd0);
    chk("clr_only_w16", {16'b0, drop_a}, 32'd0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      reset       = ($urandom_range(0, 399) != 0);
      data_valid  = ($urandom_range(0, 9) < 7);
      clear_drops = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) chan_enable = 2'($urandom);
      for (int b = 0; b < 3; b++) chan_have_space[b] = ($urandom_range(0, 9) != 0);
      d    = $urandom;
      pick = $urandom_range(0, 5);
      case (pick)
        0: d[20:16] = 5'd0;
        1: d[20:16] = 5'd1;
        2: d[20:16] = 5'd2;
        3: d[20:16] = 5'h1F;
        4: d[20:16] = 5'd3;
        default: ;
      endcase
      data_in = d;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
